// File: rtl/program_loader.sv
// program_loader: instruction memory with a streaming loader front end.
// A load session is requested with load_start while idle. The CPU is held in
// reset (cpu_hold) for the whole session. Words arrive on a valid/ready stream
// and are written to consecutive addresses from 0. The session ends on the word
// flagged with in_last, or on the DEPTH-th word, whichever comes first.
// The CPU fetch port (addr -> rd_data) is a combinational read that is always live.
//
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to add the checksum output,
// which is the running XOR of the words accepted in the current session.
//
// Ports:
//   Clk         clock, rising edge
//   rst         asynchronous reset, active low
//   load_start  start a session (only sampled in IDLE)
//   in_valid    loader word present on in_data
//   in_data     instruction word to write
//   in_last     final word of the session (qualified by in_valid)
//   in_ready    loader word accepted this cycle
//   addr        CPU fetch address
//   rd_data     instruction word at addr
//   cpu_hold    hold the CPU in reset
//   load_done   one-cycle pulse at end of session
//   word_count  words accepted in the most recent session
//   checksum    (optional) XOR of words accepted in the current session
//
// state | meaning
// IDLE  | waiting for load_start; CPU runs from memory
// LOAD  | accepting words; CPU held
// DONE  | single-cycle end-of-session pulse
module program_loader #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [3:0]       addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             cpu_hold,
  output logic             load_done,
  output logic [4:0]       word_count
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem [DEPTH];
  // One bit wider than the address so the pointer reaches DEPTH instead of
  // wrapping back to 0 on the final word of a full session.
  logic [4:0]       wr_ptr;
  logic             xfer;
  logic             last_xfer;
  logic             start;

  // Decoded from the state register rather than from in_ready to keep the
  // next-state logic free of a feedback path through its own outputs.
  assign xfer      = in_valid && (state_q == LOAD);
  assign last_xfer = xfer && (in_last || (word_count == 5'(DEPTH - 1)));
  assign start     = (state_q == IDLE) && load_start;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    cpu_hold  = 1'b0;
    load_done = 1'b0;
    case (state_q)
      IDLE: if (load_start) state_d = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (last_xfer) state_d = DONE;
      end
      DONE: begin
        load_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      word_count <= '0;
    end else if (start) begin
      wr_ptr     <= '0;
      word_count <= '0;
    end else if (xfer) begin
      wr_ptr     <= wr_ptr + 5'd1;
      word_count <= word_count + 5'd1;
    end
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (xfer) begin
      mem[wr_ptr[3:0]] <= in_data;
    end
  end

  assign rd_data = mem[addr];

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst)       checksum <= '0;
    else if (start) checksum <= '0;
    else if (xfer)  checksum <= checksum ^ in_data;
  end
`endif

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, the number of instruction words; it matches the 4-bit PC.
REQ-002 The block SHALL have parameter WIDTH, default 8, the instruction word width; it matches IR.
REQ-003 Clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; asserted while 0.
REQ-005 load_start  input  1  request to begin a load session; sampled only in IDLE.
REQ-006 in_valid  input  1  the loader stream has a word on in_data.
REQ-007 in_data  input  WIDTH  instruction word to write.
REQ-008 in_last  input  1  marks the final word of the session; meaningful only with in_valid.
REQ-009 in_ready  output  1  the block accepts in_data this cycle.
REQ-010 addr  input  4  CPU fetch address (PC).
REQ-011 rd_data  output  WIDTH  instruction word at addr, driven to the CPU's instruction input.
REQ-012 cpu_hold  output  1  the CPU must be held in reset while this is 1.
REQ-013 load_done  output  1  one-cycle pulse at the end of a session.
REQ-014 word_count  output  5  number of words accepted in the most recent session, 0..16.

Function
REQ-015 The block SHALL implement states IDLE, LOAD and DONE.
REQ-016 In IDLE, when load_start=1, the next state SHALL be LOAD; wr_ptr and word_count SHALL clear to 0.
REQ-017 In LOAD, in_ready SHALL be 1 and cpu_hold SHALL be 1; in every other state both SHALL be 0.
REQ-018 A transfer SHALL occur exactly when in_valid=1 and in_ready=1; it writes mem[wr_ptr] <= in_data and increments wr_ptr and word_count.
REQ-019 LOAD SHALL go to DONE on a transfer with in_last=1, or on the transfer that brings word_count to DEPTH, whichever comes first.
REQ-020 With in_valid=0 the block SHALL remain in LOAD indefinitely; no timeout applies.
REQ-021 DONE SHALL last one cycle with load_done=1 and SHALL then return to IDLE.
REQ-022 load_start SHALL be ignored in LOAD and DONE.
REQ-023 A new session SHALL overwrite only the words it transfers; other words keep their values.
REQ-024 rd_data SHALL equal mem[addr] combinationally at all times, including during LOAD.
REQ-025 A word written on edge N SHALL be visible on rd_data after edge N.
REQ-026 wr_ptr SHALL never wrap within a session; a 17th word cannot be accepted because the state is already DONE.
REQ-027 word_count SHALL hold its final value until the next session starts.

Reset
REQ-028 While rst=0, the block SHALL immediately enter IDLE; in_ready, cpu_hold and load_done SHALL be 0, and wr_ptr and word_count SHALL be 0.
REQ-029 Reset SHALL clear all DEPTH memory words to 0.
REQ-030 Reset asserted during LOAD SHALL abort the session with no load_done pulse.

Configuration
REQ-031 When macro PROGRAM_LOADER_CHECKSUM_EN is defined, the block SHALL add output checksum (WIDTH bits) and SHALL report in it the XOR of all words accepted in the current session.
REQ-032 With the macro defined, checksum SHALL be cleared on session start and on reset, and SHALL hold its value after DONE.
REQ-033 Without the macro, the checksum port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Reset, then read addr 0..15 -> rd_data=0x00 for all addresses; cpu_hold=0; word_count=0.
REQ-035 load_start pulse, then stream 0x11,0x22,0x33 with in_last on 0x33 -> mem[0..2]=0x11,0x22,0x33; load_done pulses once; word_count=3; cpu_hold is 1 only during LOAD; checksum=0x00 when the macro is defined.
REQ-036 Stream 16 words 0xA0..0xAF with in_last never set -> DONE after the 16th word; in_ready=0 on the next cycle; word_count=16; mem[15]=0xAF.
REQ-037 in_valid toggled 1,0,0,1 with data 0x05, then 0x06 with in_last -> exactly 2 writes, at mem[0] and mem[1]; idle cycles cause no writes.
REQ-038 rst driven to 0 after 2 of 4 words -> immediate return to IDLE; no load_done; all memory reads as 0x00.
REQ-039 Assert load_start during LOAD, then a second session of 1 word 0x7E -> the mid-session load_start has no effect; the second session writes mem[0]=0x7E and leaves mem[1..] unchanged.
